// File: rtl/comm_framer.sv
// -----------------------------------------------------------------------------
// comm_framer
//
// Full-duplex byte framer between a UART byte stream and wide matrix frames.
// A frame is {OPCODE[7:0], VALUES, INDICES}, FRAME_W = 8 + 2*DATA_W*MATRIX_N
// bits. On the wire it is sent as SYNC (0xA5), then NBYTES = FRAME_W/8 frame
// bytes MSB-first (opcode first), then an optional XOR checksum byte.
//
// Optional feature macro: COMM_CHECKSUM_EN
//   defined   : TX appends XOR of the frame bytes; RX checks it before commit.
//   undefined : no checksum byte on either side; rx_error only on timeout.
//
// Ports
//   clk            in   rising-edge clock
//   resetn         in   asynchronous active-low reset
//   rx_byte_valid  in   one-cycle strobe, rx_byte holds a received byte
//   rx_byte        in   [7:0] received byte
//   rx_data        out  [FRAME_W-1:0] last good received frame (held)
//   rx_valid       out  one-cycle pulse, rx_data just updated
//   rx_error       out  one-cycle pulse, frame discarded (checksum/timeout)
//   tx_start       in   request to send tx_data (accepted only when TX idle)
//   tx_data        in   [FRAME_W-1:0] frame to send
//   tx_byte        out  [7:0] byte to UART transmitter
//   tx_byte_valid  out  tx_byte is valid
//   tx_byte_ready  in   transmitter accepts tx_byte
//   tx_complete    out  one-cycle pulse, last byte of the frame accepted
//   busy           out  RX or TX FSM not idle
//   rx_state_dbg   out  [1:0] current RX FSM state
//   tx_state_dbg   out  [1:0] current TX FSM state
//
// TX handshake: a byte transfers on every rising edge where tx_byte_valid and
// tx_byte_ready are both high. Once tx_byte_valid is raised, tx_byte and
// tx_byte_valid stay constant until that transfer happens; tx_byte_ready may
// change freely and never depends combinationally on tx_byte_valid.
// -----------------------------------------------------------------------------
module comm_framer #(
    parameter int MATRIX_N = 4,
    parameter int DATA_W   = 16,
    parameter int TIMEOUT  = 1000000,
    localparam int FRAME_W = 8 + 2 * DATA_W * MATRIX_N
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rx_byte_valid,
    input  logic [7:0]         rx_byte,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_error,
    input  logic               tx_start,
    input  logic [FRAME_W-1:0] tx_data,
    output logic [7:0]         tx_byte,
    output logic               tx_byte_valid,
    input  logic               tx_byte_ready,
    output logic               tx_complete,
    output logic               busy,
    output logic [1:0]         rx_state_dbg,
    output logic [1:0]         tx_state_dbg
);

    localparam int NBYTES = FRAME_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int GAP_W  = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_PAYLOAD = 2'd1
`ifdef COMM_CHECKSUM_EN
        , RX_CHECK = 2'd2
`endif
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_SYNC    = 2'd1,
        TX_PAYLOAD = 2'd2
`ifdef COMM_CHECKSUM_EN
        , TX_CSUM  = 2'd3
`endif
    } tx_state_t;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    rx_state_t          rx_state, rx_next;
    logic [FRAME_W-1:0] rx_staging;
    logic [FRAME_W-1:0] rx_staging_nxt;
    logic [CNT_W-1:0]   rx_cnt;
    logic [GAP_W-1:0]   rx_gap;
    logic               rx_last;
    logic               rx_timeout;
    logic               rx_shift;
    logic               rx_commit;
    logic               rx_fail;
`ifdef COMM_CHECKSUM_EN
    logic [7:0]         rx_csum;
`endif

    assign rx_staging_nxt = {rx_staging[FRAME_W-9:0], rx_byte};
    assign rx_last        = (rx_cnt == CNT_W'(NBYTES - 1));
    // Evaluated only on cycles without a byte strobe; the strobe resets the gap.
    assign rx_timeout     = (rx_gap == GAP_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next   = rx_state;
        rx_shift  = 1'b0;
        rx_commit = 1'b0;
        rx_fail   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_byte_valid && rx_byte == SYNC_BYTE) rx_next = RX_PAYLOAD;
            end
            RX_PAYLOAD: begin
                // 0xA5 here is ordinary data; there is no resync mid-frame.
                if (rx_byte_valid) begin
                    rx_shift = 1'b1;
                    if (rx_last) begin
`ifdef COMM_CHECKSUM_EN
                        rx_next   = RX_CHECK;
`else
                        rx_commit = 1'b1;
                        rx_next   = RX_IDLE;
`endif
                    end
                end else if (rx_timeout) begin
                    rx_fail = 1'b1;
                    rx_next = RX_IDLE;
                end
            end
`ifdef COMM_CHECKSUM_EN
            RX_CHECK: begin
                if (rx_byte_valid) begin
                    rx_next = RX_IDLE;
                    if (rx_byte == rx_csum) rx_commit = 1'b1;
                    else                    rx_fail   = 1'b1;
                end else if (rx_timeout) begin
                    rx_fail = 1'b1;
                    rx_next = RX_IDLE;
                end
            end
`endif
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_error   <= 1'b0;
            rx_staging <= '0;
            rx_cnt     <= '0;
            rx_gap     <= '0;
`ifdef COMM_CHECKSUM_EN
            rx_csum    <= '0;
`endif
        end else begin
            rx_valid <= rx_commit;
            rx_error <= rx_fail;
            // A commit straight from PAYLOAD includes the byte arriving now.
            if (rx_commit) rx_data <= rx_shift ? rx_staging_nxt : rx_staging;

            if (rx_next == RX_IDLE) begin
                rx_staging <= '0;
                rx_cnt     <= '0;
                rx_gap     <= '0;
`ifdef COMM_CHECKSUM_EN
                rx_csum    <= '0;
`endif
            end else if (rx_byte_valid) begin
                rx_gap <= '0;
                if (rx_shift) begin
                    rx_staging <= rx_staging_nxt;
                    rx_cnt     <= rx_cnt + 1'b1;
`ifdef COMM_CHECKSUM_EN
                    rx_csum    <= rx_csum ^ rx_byte;
`endif
                end
            end else begin
                rx_gap <= rx_gap + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t          tx_state, tx_next;
    logic [FRAME_W-1:0] tx_shift;
    logic [CNT_W-1:0]   tx_cnt;
    logic               tx_last;
    logic               tx_done;
`ifdef COMM_CHECKSUM_EN
    logic [7:0]         tx_csum;
`endif

    assign tx_last = (tx_cnt == CNT_W'(NBYTES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tx_state <= TX_IDLE;
        else         tx_state <= tx_next;
    end

    always_comb begin
        tx_next       = tx_state;
        tx_byte       = 8'h00;
        tx_byte_valid = 1'b0;
        tx_done       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_start) tx_next = TX_SYNC;
            end
            TX_SYNC: begin
                tx_byte       = SYNC_BYTE;
                tx_byte_valid = 1'b1;
                if (tx_byte_ready) tx_next = TX_PAYLOAD;
            end
            TX_PAYLOAD: begin
                tx_byte       = tx_shift[FRAME_W-1 -: 8];
                tx_byte_valid = 1'b1;
                if (tx_byte_ready && tx_last) begin
`ifdef COMM_CHECKSUM_EN
                    tx_next = TX_CSUM;
`else
                    tx_next = TX_IDLE;
                    tx_done = 1'b1;
`endif
                end
            end
`ifdef COMM_CHECKSUM_EN
            TX_CSUM: begin
                tx_byte       = tx_csum;
                tx_byte_valid = 1'b1;
                if (tx_byte_ready) begin
                    tx_next = TX_IDLE;
                    tx_done = 1'b1;
                end
            end
`endif
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_shift    <= '0;
            tx_cnt      <= '0;
            tx_complete <= 1'b0;
`ifdef COMM_CHECKSUM_EN
            tx_csum     <= '0;
`endif
        end else begin
            tx_complete <= tx_done;
            if (tx_state == TX_IDLE && tx_start) begin
                // Frame is latched here so later tx_data changes cannot leak in.
                tx_shift <= tx_data;
                tx_cnt   <= '0;
`ifdef COMM_CHECKSUM_EN
                tx_csum  <= '0;
`endif
            end else if (tx_state == TX_PAYLOAD && tx_byte_ready) begin
                tx_shift <= {tx_shift[FRAME_W-9:0], 8'h00};
                tx_cnt   <= tx_cnt + 1'b1;
`ifdef COMM_CHECKSUM_EN
                tx_csum  <= tx_csum ^ tx_shift[FRAME_W-1 -: 8];
`endif
            end
        end
    end

    assign busy         = (rx_state != RX_IDLE) || (tx_state != TX_IDLE);
    assign rx_state_dbg = rx_state;
    assign tx_state_dbg = tx_state;

endmodule

// File: tb/tb_comm_framer.sv
// -----------------------------------------------------------------------------
// tb_comm_framer
//
// Drives random UART byte streams into the RX side and random frames into the
// TX side (with a randomly toggling tx_byte_ready), and compares the DUT with
// a frame-level reference: expected RX frames and expected TX byte streams are
// built directly from the frame contents (split into bytes, XOR checksum).
// Works with and without COMM_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_comm_framer;

  localparam int MATRIX_N = 4;
  localparam int DATA_W   = 16;
  localparam int TIMEOUT  = 100;
  localparam int FRAME_W  = 8 + 2 * DATA_W * MATRIX_N;
  localparam int NBYTES   = FRAME_W / 8;

  typedef logic [FRAME_W-1:0] frame_t;

  logic         clk;
  logic         resetn;
  logic         rx_byte_valid;
  logic [7:0]   rx_byte;
  frame_t       rx_data;
  logic         rx_valid;
  logic         rx_error;
  logic         tx_start;
  frame_t       tx_data;
  logic [7:0]   tx_byte;
  logic         tx_byte_valid;
  logic         tx_byte_ready;
  logic         tx_complete;
  logic         busy;
  logic [1:0]   rx_state_dbg;
  logic [1:0]   tx_state_dbg;

  comm_framer #(
    .MATRIX_N (MATRIX_N),
    .DATA_W   (DATA_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte       (rx_byte),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_error      (rx_error),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_byte       (tx_byte),
    .tx_byte_valid (tx_byte_valid),
    .tx_byte_ready (tx_byte_ready),
    .tx_complete   (tx_complete),
    .busy          (busy),
    .rx_state_dbg  (rx_state_dbg),
    .tx_state_dbg  (tx_state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input frame_t obs, input frame_t exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] frame_byte(input frame_t f, input int i);
    frame_t t;
    t = f >> (8 * (NBYTES - 1 - i));
    return t[7:0];
  endfunction

  function automatic logic [7:0] frame_csum(input frame_t f);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < NBYTES; i++) c = c ^ frame_byte(f, i);
    return c;
  endfunction

  function automatic frame_t random_frame();
    frame_t f;
    f = '0;
    for (int i = 0; i < NBYTES; i++) f = (f << 8) | frame_t'($urandom_range(0, 255));
    return f;
  endfunction

  frame_t     exp_q[$];     // frames RX must commit, in order
  logic [7:0] tx_exp_q[$];  // bytes TX must deliver, in order
  frame_t     last_good;    // most recent frame RX should be holding
  int         rx_valid_cnt = 0;
  int         rx_err_cnt   = 0;
  int         tx_done_cnt  = 0;
  logic       tx_stall     = 1'b0;
  logic [7:0] stall_byte   = 8'h00;

  // ---------------- scoreboard / monitors (sample on falling edge) ----------------
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_valid_cnt++;
      check("rx_expected_avail", frame_t'(exp_q.size() != 0), frame_t'(1));
      if (exp_q.size() != 0) begin
        last_good = exp_q.pop_front();
        check("rx_data", rx_data, last_good);
      end
    end
    if (rx_error) rx_err_cnt++;
    if (tx_complete) begin
      tx_done_cnt++;
      check("tx_all_bytes_sent", frame_t'(tx_exp_q.size()), frame_t'(0));
    end
    if (tx_stall && tx_byte_valid) check("tx_byte_stable", frame_t'(tx_byte), frame_t'(stall_byte));
    if (tx_byte_valid && tx_byte_ready) begin
      check("tx_expected_avail", frame_t'(tx_exp_q.size() != 0), frame_t'(1));
      if (tx_exp_q.size() != 0) check("tx_byte", frame_t'(tx_byte), frame_t'(tx_exp_q.pop_front()));
    end
    tx_stall   = tx_byte_valid && !tx_byte_ready;
    stall_byte = tx_byte;
  end

  // ---------------- ready driver ----------------
  initial begin
    tx_byte_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_byte_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic rx_put(input logic [7:0] b, input int gap);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
    rx_byte       = 8'($urandom_range(0, 255));
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends junk, SYNC, frame bytes and (if enabled) checksum XORed with csum_flip.
  task automatic rx_send_frame(input frame_t f, input int junk, input int gap_max,
                               input logic [7:0] csum_flip);
    logic [7:0] j;
    for (int i = 0; i < junk; i++) begin
      j = 8'($urandom_range(0, 255));
      if (j == 8'hA5) j = 8'h5A;
      rx_put(j, $urandom_range(0, gap_max));
    end
    rx_put(8'hA5, $urandom_range(0, gap_max));
    for (int i = 0; i < NBYTES; i++) rx_put(frame_byte(f, i), $urandom_range(0, gap_max));
`ifdef COMM_CHECKSUM_EN
    rx_put(frame_csum(f) ^ csum_flip, 0);
`else
    if (csum_flip != 8'h00) $display("note: checksum disabled, flip ignored");
`endif
  endtask

  task automatic tx_begin(input frame_t f);
    tx_data  = f;
    tx_start = 1'b1;
    tx_exp_q.push_back(8'hA5);
    for (int i = 0; i < NBYTES; i++) tx_exp_q.push_back(frame_byte(f, i));
`ifdef COMM_CHECKSUM_EN
    tx_exp_q.push_back(frame_csum(f));
`endif
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_data  = random_frame();
  endtask

  task automatic tx_wait(input int base, input int budget);
    int n;
    n = 0;
    while (tx_done_cnt == base && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("tx_done_in_time", frame_t'(tx_done_cnt > base), frame_t'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_checks();
    check("rst_rx_data", rx_data, frame_t'(0));
    check("rst_rx_valid", frame_t'(rx_valid), frame_t'(0));
    check("rst_rx_error", frame_t'(rx_error), frame_t'(0));
    check("rst_tx_byte", frame_t'(tx_byte), frame_t'(0));
    check("rst_tx_byte_valid", frame_t'(tx_byte_valid), frame_t'(0));
    check("rst_tx_complete", frame_t'(tx_complete), frame_t'(0));
    check("rst_busy", frame_t'(busy), frame_t'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    frame_t seq_frame, f, g;
    int base_v, base_e, base_t, n, exp_err;

    resetn        = 1'b0;
    rx_byte_valid = 1'b0;
    rx_byte       = 8'h00;
    tx_start      = 1'b0;
    tx_data       = '0;
    last_good     = '0;
    exp_err       = 0;
    seq_frame     = '0;
    for (int i = 0; i < NBYTES; i++) seq_frame = (seq_frame << 8) | frame_t'(i + 1);

    idle(3);
    reset_checks();
    resetn = 1'b1;
    idle(2);

    // Known frame preceded by a stray byte.
    base_v = rx_valid_cnt;
    base_e = rx_err_cnt;
    exp_q.push_back(seq_frame);
    rx_put(8'h00, 0);
    rx_send_frame(seq_frame, 0, 0, 8'h00);
    idle(4);
    check("seq_rx_valid_once", frame_t'(rx_valid_cnt - base_v), frame_t'(1));
    check("seq_rx_no_error", frame_t'(rx_err_cnt - base_e), frame_t'(0));
    check("seq_rx_hold", rx_data, seq_frame);

`ifdef COMM_CHECKSUM_EN
    // Wrong checksum (0x00) must be rejected without touching rx_data.
    base_v = rx_valid_cnt;
    base_e = rx_err_cnt;
    rx_send_frame(seq_frame, 0, 1, frame_csum(seq_frame));
    idle(4);
    exp_err++;
    check("badcs_error", frame_t'(rx_err_cnt - base_e), frame_t'(1));
    check("badcs_no_valid", frame_t'(rx_valid_cnt - base_v), frame_t'(0));
    check("badcs_hold", rx_data, last_good);
`endif

    // Timeout: SYNC plus 5 bytes, then silence.
    base_v = rx_valid_cnt;
    base_e = rx_err_cnt;
    rx_put(8'hA5, 0);
    for (int i = 0; i < 5; i++) rx_put(8'($urandom_range(0, 255)), 0);
    n = 0;
    while (rx_err_cnt == base_e && n < TIMEOUT + 50) begin
      @(posedge clk); #1;
      n++;
    end
    exp_err++;
    check("tmo_error", frame_t'(rx_err_cnt - base_e), frame_t'(1));
    check("tmo_latency_window", frame_t'(n >= TIMEOUT - 2 && n <= TIMEOUT + 3), frame_t'(1));
    check("tmo_no_valid", frame_t'(rx_valid_cnt - base_v), frame_t'(0));
    check("tmo_hold", rx_data, last_good);

    // Good frame afterwards, with one long (sub-timeout) gap at the boundary.
    f = random_frame();
    exp_q.push_back(f);
    rx_put(8'hA5, TIMEOUT - 5);
    for (int i = 0; i < NBYTES; i++) rx_put(frame_byte(f, i), (i == 3) ? TIMEOUT - 5 : 0);
`ifdef COMM_CHECKSUM_EN
    rx_put(frame_csum(f), 0);
`endif
    idle(4);
    check("post_tmo_commit", rx_data, f);

    // Known TX frame with random backpressure.
    base_t = tx_done_cnt;
    tx_begin(seq_frame);
    tx_wait(base_t, 500);
    idle(3);
    check("seq_tx_once", frame_t'(tx_done_cnt - base_t), frame_t'(1));
    check("idle_busy", frame_t'(busy), frame_t'(0));

    // Random frames, RX and TX in parallel, second tx_start mid-frame ignored.
    for (int k = 0; k < 4; k++) begin
      f = random_frame();
      g = random_frame();
      if (k == 0) f[FRAME_W-1 -: 8] = 8'hA5;  // 0xA5 as payload, not resync
      exp_q.push_back(f);
      base_t = tx_done_cnt;
      fork
        rx_send_frame(f, $urandom_range(0, 3), 3, 8'h00);
        begin
          tx_begin(g);
          idle($urandom_range(3, 10));
          tx_data  = random_frame();
          tx_start = 1'b1;
          idle(1);
          tx_start = 1'b0;
          tx_wait(base_t, 500);
        end
      join
      idle(30);
      check("dup_tx_once", frame_t'(tx_done_cnt - base_t), frame_t'(1));
      check("dup_rx_commit", rx_data, f);
    end

    // Reset in the middle of RX payload and TX payload.
    tx_begin(random_frame());
    rx_put(8'hA5, 0);
    for (int i = 0; i < 6; i++) rx_put(8'($urandom_range(0, 255)), 0);
    base_v = rx_valid_cnt;
    base_e = rx_err_cnt;
    base_t = tx_done_cnt;
    resetn = 1'b0;
    tx_exp_q.delete();
    last_good = '0;
    #1;
    reset_checks();
    idle(3);
    resetn = 1'b1;
    idle(TIMEOUT + 20);
    check("rst_no_rx_valid", frame_t'(rx_valid_cnt - base_v), frame_t'(0));
    check("rst_no_rx_error", frame_t'(rx_err_cnt - base_e), frame_t'(0));
    check("rst_no_tx_done", frame_t'(tx_done_cnt - base_t), frame_t'(0));

    f = random_frame();
    g = random_frame();
    exp_q.push_back(f);
    base_t = tx_done_cnt;
    fork
      rx_send_frame(f, 1, 2, 8'h00);
      begin
        tx_begin(g);
        tx_wait(base_t, 500);
      end
    join
    idle(5);
    check("after_rst_rx", rx_data, f);

    // Final accounting.
    check("rx_queue_drained", frame_t'(exp_q.size()), frame_t'(0));
    check("tx_queue_drained", frame_t'(tx_exp_q.size()), frame_t'(0));
    check("rx_error_total", frame_t'(rx_err_cnt), frame_t'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
